// File: rtl/rvc_asap_pkg.sv
// Shared definitions for the control-register responder: register word
// offsets, blank 7-seg pattern, register field types and load formatting.
package rvc_asap_pkg;

    // Word offsets (AluOut[5:2]) of the control registers
    localparam logic [3:0] CR_SEG7_0 = 4'd0;
    localparam logic [3:0] CR_SEG7_1 = 4'd1;
    localparam logic [3:0] CR_SEG7_2 = 4'd2;
    localparam logic [3:0] CR_SEG7_3 = 4'd3;
    localparam logic [3:0] CR_SEG7_4 = 4'd4;
    localparam logic [3:0] CR_SEG7_5 = 4'd5;
    localparam logic [3:0] CR_LED    = 4'd6;
    localparam logic [3:0] CR_BTN0   = 4'd7;
    localparam logic [3:0] CR_BTN1   = 4'd8;
    localparam logic [3:0] CR_SWITCH = 4'd9;

    localparam int unsigned CR_RW_NUM = 7;

    // Active-low segments: all ones turns every segment off
    localparam logic [6:0] SEG7_BLANK = 7'h7F;

    typedef struct packed {
        logic press_sticky;
        logic level;
    } t_cr_btn;

    typedef logic [6:0] t_cr_rw;

    // Zero the bytes that are not enabled, then sign-extend byte/half loads
    function automatic logic [31:0] cr_load_format(input logic [31:0] data,
                                                   input logic [3:0]  byte_en,
                                                   input logic        sign_ext);
        logic [31:0] masked;
        for (int unsigned i = 0; i < 4; i++) begin
            masked[i*8 +: 8] = byte_en[i] ? data[i*8 +: 8] : 8'h00;
        end
        if (sign_ext && byte_en == 4'b0001) begin
            masked = {{24{masked[7]}}, masked[7:0]};
        end else if (sign_ext && byte_en == 4'b0011) begin
            masked = {{16{masked[15]}}, masked[15:0]};
        end
        return masked;
    endfunction

endpackage

// File: rtl/rvc_asap_debounce.sv
// Two-flop synchronizer followed by a stability counter. The accepted level
// flips only after the synced input has differed from it for DEBOUNCE_CYC
// consecutive cycles; rise pulses on the cycle the level goes 0->1.
module rvc_asap_debounce #(
    parameter logic [15:0] DEBOUNCE_CYC = 16'd50000
) (
    input  logic Clock,
    input  logic Rst,
    input  logic raw,
    output logic level,
    output logic rise
);

    logic        sync_1;
    logic        sync_2;
    logic [15:0] cnt;
    logic        at_limit;

    assign at_limit = (cnt == DEBOUNCE_CYC - 16'd1);
    assign rise     = (sync_2 != level) && at_limit && sync_2;

    // Synchronize the raw input and debounce it into the accepted level
    always_ff @(posedge Clock or negedge Rst) begin
        if (!Rst) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
            cnt    <= '0;
            level  <= 1'b0;
        end else begin
            sync_1 <= raw;
            sync_2 <= sync_1;
            if (sync_2 == level) begin
                cnt <= '0;
            end else if (at_limit) begin
                level <= sync_2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 16'd1;
            end
        end
    end

endmodule

// File: rtl/rvc_asap_cr_mem_5pl.sv
// Control-register responder beside D_MEM: decodes Q103H loads/stores into
// the CR window, holds the 7-seg/LED registers, reads the debounced buttons
// and synced switches, and returns load data registered into Q104H.
module rvc_asap_cr_mem_5pl
    import rvc_asap_pkg::*;
#(
    parameter logic [31:0] CR_BASE      = 32'h00FE_0000,
    parameter logic [15:0] DEBOUNCE_CYC = 16'd50000
) (
    input  logic        Clock,
    input  logic        Rst,
    input  logic [31:0] AluOut,
    input  logic [31:0] RegRdData2,
    input  logic [3:0]  CtrlDMemByteEn,
    input  logic        CtrlDMemWrEn,
    input  logic        SelDMemWb,
    input  logic        CtrlSignExt,
    output logic [31:0] CrRdDataQ104H,
    output logic        CrHitQ104H,
    input  logic        Button_0,
    input  logic        Button_1,
    input  logic [9:0]  Switch,
    output logic [6:0]  SEG7_0,
    output logic [6:0]  SEG7_1,
    output logic [6:0]  SEG7_2,
    output logic [6:0]  SEG7_3,
    output logic [6:0]  SEG7_4,
    output logic [6:0]  SEG7_5,
    output logic [6:0]  LED
);

    logic        hit;
    logic [3:0]  offset;
    logic        load_hit;
    logic        store_hit;
    logic [31:0] rd_raw;
    logic [31:0] rd_fmt;
    logic [1:0]  btn_level;
    logic [1:0]  btn_rise;
    logic [1:0]  btn_sticky;
    logic [1:0]  btn_clear;
    logic [9:0]  sw_sync_1;
    logic [9:0]  sw_sync_2;
    t_cr_rw      rw_q [CR_RW_NUM];
    t_cr_btn     btn0_view;
    t_cr_btn     btn1_view;
    logic        unused_bits;

    assign unused_bits = ^{AluOut[1:0], RegRdData2[31:7]};

    assign hit       = (AluOut[31:6] == CR_BASE[31:6]);
    assign offset    = AluOut[5:2];
    assign load_hit  = SelDMemWb && hit;
    assign store_hit = CtrlDMemWrEn && hit && CtrlDMemByteEn[0];

    assign btn_clear[0] = load_hit && (offset == CR_BTN0);
    assign btn_clear[1] = load_hit && (offset == CR_BTN1);

    assign btn0_view = '{press_sticky: btn_sticky[0], level: btn_level[0]};
    assign btn1_view = '{press_sticky: btn_sticky[1], level: btn_level[1]};

    assign SEG7_0 = rw_q[0];
    assign SEG7_1 = rw_q[1];
    assign SEG7_2 = rw_q[2];
    assign SEG7_3 = rw_q[3];
    assign SEG7_4 = rw_q[4];
    assign SEG7_5 = rw_q[5];
    assign LED    = rw_q[6];

    rvc_asap_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_debounce_btn0 (
        .Clock (Clock),
        .Rst   (Rst),
        .raw   (Button_0),
        .level (btn_level[0]),
        .rise  (btn_rise[0])
    );

    rvc_asap_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_debounce_btn1 (
        .Clock (Clock),
        .Rst   (Rst),
        .raw   (Button_1),
        .level (btn_level[1]),
        .rise  (btn_rise[1])
    );

    // Read mux over the CR map; unmapped offsets inside the window read 0
    always_comb begin
        rd_raw = '0;
        case (offset)
            CR_SEG7_0, CR_SEG7_1, CR_SEG7_2, CR_SEG7_3,
            CR_SEG7_4, CR_SEG7_5, CR_LED: rd_raw = {25'b0, rw_q[offset[2:0]]};
            CR_BTN0:                      rd_raw = {30'b0, btn0_view};
            CR_BTN1:                      rd_raw = {30'b0, btn1_view};
            CR_SWITCH:                    rd_raw = {22'b0, sw_sync_2};
            default:                      rd_raw = '0;
        endcase
    end

    assign rd_fmt = cr_load_format(rd_raw, CtrlDMemByteEn, CtrlSignExt);

    // Writable display registers; only the low byte lane carries their data
    always_ff @(posedge Clock or negedge Rst) begin
        if (!Rst) begin
            for (int unsigned i = 0; i < CR_RW_NUM - 1; i++) begin
                rw_q[i] <= SEG7_BLANK;
            end
            rw_q[CR_RW_NUM-1] <= '0;
        end else if (store_hit && offset < CR_LED + 4'd1) begin
            rw_q[offset[2:0]] <= RegRdData2[6:0];
        end
    end

    // Sticky press flags: a rise on the clearing read's cycle keeps the flag set
    always_ff @(posedge Clock or negedge Rst) begin
        if (!Rst) begin
            btn_sticky <= '0;
        end else begin
            btn_sticky <= btn_rise | (btn_sticky & ~btn_clear);
        end
    end

    // Two-flop synchronizer for the switch bank
    always_ff @(posedge Clock or negedge Rst) begin
        if (!Rst) begin
            sw_sync_1 <= '0;
            sw_sync_2 <= '0;
        end else begin
            sw_sync_1 <= Switch;
            sw_sync_2 <= sw_sync_1;
        end
    end

    // Q104H load result: data of a CR hit, zero for misses or no load
    always_ff @(posedge Clock or negedge Rst) begin
        if (!Rst) begin
            CrRdDataQ104H <= '0;
            CrHitQ104H    <= 1'b0;
        end else if (load_hit) begin
            CrRdDataQ104H <= rd_fmt;
            CrHitQ104H    <= 1'b1;
        end else begin
            CrRdDataQ104H <= '0;
            CrHitQ104H    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rvc_asap_cr_mem_5pl.sv
// Self-checking bench for the CR responder: directed steps followed by
// randomized traffic, all compared every cycle against a behavioural model.
module tb_rvc_asap_cr_mem_5pl;

    localparam logic [31:0] BASE = 32'h00FE_0000;
    localparam int          DEB  = 4;

    logic        Clock = 1'b0;
    logic        Rst;
    logic [31:0] AluOut;
    logic [31:0] RegRdData2;
    logic [3:0]  CtrlDMemByteEn;
    logic        CtrlDMemWrEn;
    logic        SelDMemWb;
    logic        CtrlSignExt;
    logic [31:0] CrRdDataQ104H;
    logic        CrHitQ104H;
    logic        Button_0;
    logic        Button_1;
    logic [9:0]  Switch;
    logic [6:0]  SEG7_0, SEG7_1, SEG7_2, SEG7_3, SEG7_4, SEG7_5, LED;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    logic [6:0]  m_rw [7];
    logic        m_bs1 [2];
    logic        m_bs2 [2];
    logic        m_lvl [2];
    logic        m_stk [2];
    int          m_run [2];
    logic [9:0]  m_sw1, m_sw2;
    logic [31:0] m_rd;
    logic        m_hit;

    always #5 Clock = ~Clock;

    rvc_asap_cr_mem_5pl #(.CR_BASE(BASE), .DEBOUNCE_CYC(16'd4)) dut (
        .Clock          (Clock),
        .Rst            (Rst),
        .AluOut         (AluOut),
        .RegRdData2     (RegRdData2),
        .CtrlDMemByteEn (CtrlDMemByteEn),
        .CtrlDMemWrEn   (CtrlDMemWrEn),
        .SelDMemWb      (SelDMemWb),
        .CtrlSignExt    (CtrlSignExt),
        .CrRdDataQ104H  (CrRdDataQ104H),
        .CrHitQ104H     (CrHitQ104H),
        .Button_0       (Button_0),
        .Button_1       (Button_1),
        .Switch         (Switch),
        .SEG7_0         (SEG7_0),
        .SEG7_1         (SEG7_1),
        .SEG7_2         (SEG7_2),
        .SEG7_3         (SEG7_3),
        .SEG7_4         (SEG7_4),
        .SEG7_5         (SEG7_5),
        .LED            (LED)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 6; i++) m_rw[i] = 7'h7F;
        m_rw[6] = 7'h00;
        for (int b = 0; b < 2; b++) begin
            m_bs1[b] = 0; m_bs2[b] = 0; m_lvl[b] = 0; m_stk[b] = 0; m_run[b] = 0;
        end
        m_sw1 = '0; m_sw2 = '0; m_rd = '0; m_hit = 0;
    endtask

    // Value a load of the given register word returns, before masking
    function automatic logic [31:0] reg_value(input int word);
        if (word < 7)       return 32'(m_rw[word]);
        else if (word == 7) return (m_stk[0] ? 32'd2 : 32'd0) + (m_lvl[0] ? 32'd1 : 32'd0);
        else if (word == 8) return (m_stk[1] ? 32'd2 : 32'd0) + (m_lvl[1] ? 32'd1 : 32'd0);
        else if (word == 9) return 32'(m_sw2);
        return 32'd0;
    endfunction

    // One clock edge of the reference behaviour, using the inputs held at the edge
    task automatic model_edge();
        bit          in_win;
        int          word;
        logic [31:0] v;
        logic        raw_b [2];
        in_win = (AluOut >= BASE) && (AluOut < BASE + 32'd64);
        word   = int'((AluOut - BASE) / 4);
        raw_b[0] = Button_0;
        raw_b[1] = Button_1;
        // load result computed from pre-edge state
        if (SelDMemWb && in_win) begin
            v = reg_value(word);
            if (!CtrlDMemByteEn[0]) v = v & 32'hFFFF_FF00;
            if (!CtrlDMemByteEn[1]) v = v & 32'hFFFF_00FF;
            if (!CtrlDMemByteEn[2]) v = v & 32'hFF00_FFFF;
            if (!CtrlDMemByteEn[3]) v = v & 32'h00FF_FFFF;
            if (CtrlSignExt && CtrlDMemByteEn == 4'b0001 && v >= 32'h80) v = v + 32'hFFFF_FF00;
            if (CtrlSignExt && CtrlDMemByteEn == 4'b0011 && v >= 32'h8000) v = v + 32'hFFFF_0000;
            m_rd = v; m_hit = 1;
        end else begin
            m_rd = 0; m_hit = 0;
        end
        // buttons: level accepted after DEB consecutive differing synced samples
        for (int b = 0; b < 2; b++) begin
            bit rose = 0;
            if (m_bs2[b] != m_lvl[b]) begin
                m_run[b]++;
                if (m_run[b] == DEB) begin
                    m_lvl[b] = m_bs2[b];
                    m_run[b] = 0;
                    rose = m_lvl[b];
                end
            end else begin
                m_run[b] = 0;
            end
            if (SelDMemWb && in_win && word == 7 + b) m_stk[b] = 0;
            if (rose) m_stk[b] = 1;
            m_bs2[b] = m_bs1[b];
            m_bs1[b] = raw_b[b];
        end
        m_sw2 = m_sw1;
        m_sw1 = Switch;
        // store lands after the load sampled the old value
        if (CtrlDMemWrEn && in_win && CtrlDMemByteEn[0] && word < 7) m_rw[word] = RegRdData2[6:0];
    endtask

    task automatic check_all();
        chk("SEG7_0", 32'(SEG7_0), 32'(m_rw[0]));
        chk("SEG7_1", 32'(SEG7_1), 32'(m_rw[1]));
        chk("SEG7_2", 32'(SEG7_2), 32'(m_rw[2]));
        chk("SEG7_3", 32'(SEG7_3), 32'(m_rw[3]));
        chk("SEG7_4", 32'(SEG7_4), 32'(m_rw[4]));
        chk("SEG7_5", 32'(SEG7_5), 32'(m_rw[5]));
        chk("LED", 32'(LED), 32'(m_rw[6]));
        chk("hit", 32'(CrHitQ104H), 32'(m_hit));
        chk("rddata", CrRdDataQ104H, m_rd);
    endtask

    task automatic step();
        @(posedge Clock);
        if (Rst) model_edge();
        else     model_reset();
        #1;
        check_all();
    endtask

    task automatic idle();
        AluOut = '0; RegRdData2 = '0; CtrlDMemByteEn = '0;
        CtrlDMemWrEn = 0; SelDMemWb = 0; CtrlSignExt = 0;
    endtask

    task automatic do_load(input logic [31:0] a, input logic [3:0] be, input logic sx);
        idle();
        AluOut = a; CtrlDMemByteEn = be; SelDMemWb = 1; CtrlSignExt = sx;
        step();
    endtask

    task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        idle();
        AluOut = a; RegRdData2 = d; CtrlDMemByteEn = be; CtrlDMemWrEn = 1;
        step();
    endtask

    initial begin
        bit found;
        Rst = 0; Button_0 = 0; Button_1 = 0; Switch = '0;
        idle();
        model_reset();
        repeat (3) step();
        chk("reset_seg0", 32'(SEG7_0), 32'h7F);
        chk("reset_led", 32'(LED), 32'h0);
        Rst = 1;

        // RW register store and load-back
        do_store(BASE + 32'h18, 32'h5A, 4'hF);
        chk("led_store", 32'(LED), 32'h5A);
        do_load(BASE + 32'h18, 4'hF, 0);
        chk("led_load", CrRdDataQ104H, 32'h5A);
        chk("led_hit", 32'(CrHitQ104H), 32'h1);

        // byte load with sign extension, store without byte lane 0
        do_load(BASE + 32'h08, 4'b0001, 1);
        chk("lb_sext", CrRdDataQ104H, 32'h7F);
        do_store(BASE + 32'h08, 32'h0000_1100, 4'b0010);
        chk("seg2_noupd", 32'(SEG7_2), 32'h7F);
        do_store(BASE + 32'h08, 32'h45, 4'b0001);
        do_load(BASE + 32'h08, 4'b0011, 1);
        chk("lh_sext", CrRdDataQ104H, 32'h45);

        // switch synchronizer
        Switch = 10'h2A5;
        idle(); step(); step();
        do_load(BASE + 32'h24, 4'hF, 0);
        chk("switch", CrRdDataQ104H, 32'h2A5);

        // miss, unmapped read and ignored stores
        do_load(BASE - 32'd4, 4'hF, 0);
        chk("miss_hit", 32'(CrHitQ104H), 32'h0);
        chk("miss_data", CrRdDataQ104H, 32'h0);
        do_load(BASE + 32'h30, 4'hF, 0);
        chk("unmap_hit", 32'(CrHitQ104H), 32'h1);
        chk("unmap_data", CrRdDataQ104H, 32'h0);
        do_store(BASE + 32'h30, 32'hFF, 4'hF);
        do_store(BASE + 32'h1C, 32'hFF, 4'hF);

        // button glitch shorter than the debounce window
        Button_0 = 1; idle(); repeat (3) step();
        Button_0 = 0; repeat (6) step();
        do_load(BASE + 32'h1C, 4'hF, 0);
        chk("glitch", CrRdDataQ104H, 32'h0);

        // held press, then read-clear of the sticky bit
        Button_0 = 1; idle(); repeat (8) step();
        do_load(BASE + 32'h1C, 4'hF, 0);
        chk("press_rd1", CrRdDataQ104H, 32'h3);
        do_load(BASE + 32'h1C, 4'hF, 0);
        chk("press_rd2", CrRdDataQ104H, 32'h1);
        do_store(BASE + 32'h1C, 32'h0, 4'hF);

        // release, then a press whose rise coincides with a clearing read
        Button_0 = 0; idle(); repeat (8) step();
        Button_0 = 1;
        found = 0;
        for (int i = 0; i < 12 && !found; i++) begin
            if (m_bs2[0] && !m_lvl[0] && m_run[0] == DEB - 1) begin
                do_load(BASE + 32'h1C, 4'hF, 0);
                found = 1;
            end else begin
                idle(); step();
            end
        end
        chk("rise_seen", 32'(found), 32'h1);
        do_load(BASE + 32'h1C, 4'hF, 0);
        chk("press_keep", CrRdDataQ104H, 32'h3);

        // randomized traffic with an asynchronous reset in the middle
        for (int n = 0; n < 400; n++) begin
            idle();
            if ($urandom_range(0, 9) == 0) AluOut = $urandom;
            else AluOut = BASE + 32'($urandom_range(0, 63));
            RegRdData2     = $urandom;
            CtrlDMemByteEn = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 2) == 0) CtrlDMemByteEn = 4'b0001;
            CtrlDMemWrEn   = ($urandom_range(0, 2) == 0);
            SelDMemWb      = ($urandom_range(0, 1) == 1);
            CtrlSignExt    = ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 7) == 0) Button_0 = ~Button_0;
            if ($urandom_range(0, 7) == 0) Button_1 = ~Button_1;
            if ($urandom_range(0, 15) == 0) Switch = 10'($urandom);
            if (n == 200) begin
                #3;
                Rst = 0;
                model_reset();
                #1;
                chk("arst_seg5", 32'(SEG7_5), 32'h7F);
                chk("arst_led", 32'(LED), 32'h0);
                chk("arst_hit", 32'(CrHitQ104H), 32'h0);
                chk("arst_data", CrRdDataQ104H, 32'h0);
                repeat (3) step();
                Rst = 1;
            end else begin
                step();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
